hring_node_port_ctrl: RTL and testbench

- Per-node local-port controller at the local side of the hierarchical-ring node router.
- Injects core flits into one local router port (portl_ci, qualified by portl_ack) and sinks ejected flits from that port's output (portl_co).
- Buffers both directions so the core can apply backpressure while the bufferless router never stalls.
- Instantiated twice per node, once per local port pair (l0, l1).

---
 rtl/hring_node_port_ctrl_pkg.sv | 41 ++++
 rtl/hring_node_port_ctrl_if.sv | 50 +++++
 rtl/hring_node_port_ctrl_sync_fifo.sv | 86 ++++++++
 rtl/hring_node_port_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hring_node_port_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hring_node_port_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hring_node_port_ctrl_pkg
// Shared flit-format constants and defaults for the local-port controller of
// the hierarchical-ring node router.
//   CONTROL_W        : width of a router control flit
//   CTRL_VALID       : index of the flit-present bit
//   CTRL_DEST_HI/LO  : destination field range inside a flit
//   STARVE_LIMIT_DEF : default consecutive un-acked offer cycles before starve
//   CNT_W_DEF        : default width of the injected-flit counter
// ---------------------------------------------------------------------------
package hring_node_port_ctrl_pkg;

    localparam int CONTROL_W        = 144;
    localparam int CTRL_VALID       = 143;
    localparam int CTRL_DEST_HI     = 142;
    localparam int CTRL_DEST_LO     = 139;

    localparam int STARVE_LIMIT_DEF = 16;
    localparam int CNT_W_DEF        = 16;

    typedef logic [CONTROL_W-1:0] flit_t;

    // Return the flit with its flit-present bit set.
    function automatic flit_t mark_valid(input flit_t f);
        flit_t r;
        r             = f;
        r[CTRL_VALID] = 1'b1;
        return r;
    endfunction

    // Flit-present bit of a flit.
    function automatic logic flit_present(input flit_t f);
        return f[CTRL_VALID];
    endfunction

    // Destination field of a flit.
    function automatic logic [CTRL_DEST_HI-CTRL_DEST_LO:0] flit_dest(input flit_t f);
        return f[CTRL_DEST_HI:CTRL_DEST_LO];
    endfunction

endpackage

// File: rtl/hring_node_port_ctrl_if.sv
// ---------------------------------------------------------------------------
// hring_node_port_ctrl_if
// Handshake/bus bundle between a core, the local-port controller and one
// local router port.
//   core_in_flit/valid/ready    : core -> controller injection handshake
//   portl_ci/portl_ack          : controller -> router local input, ack back
//   portl_co                    : router local output (ejection), no backpressure
//   core_out_flit/valid/ready   : controller -> core ejection handshake
// Modports:
//   slave  : the controller side
//   master : the surrounding core/router side
// ---------------------------------------------------------------------------
interface hring_node_port_ctrl_if;
    import hring_node_port_ctrl_pkg::*;

    flit_t core_in_flit;
    logic  core_in_valid;
    logic  core_in_ready;
    flit_t portl_ci;
    logic  portl_ack;
    flit_t portl_co;
    flit_t core_out_flit;
    logic  core_out_valid;
    logic  core_out_ready;

    modport slave (
        input  core_in_flit,
        input  core_in_valid,
        output core_in_ready,
        output portl_ci,
        input  portl_ack,
        input  portl_co,
        output core_out_flit,
        output core_out_valid,
        input  core_out_ready
    );

    modport master (
        output core_in_flit,
        output core_in_valid,
        input  core_in_ready,
        input  portl_ci,
        output portl_ack,
        output portl_co,
        input  core_out_flit,
        input  core_out_valid,
        output core_out_ready
    );

endinterface

// File: rtl/hring_node_port_ctrl_sync_fifo.sv
// ---------------------------------------------------------------------------
// hring_sync_fifo
// Synchronous FIFO with synchronous active-high reset.
//   clk, rst   : clock, synchronous reset (clears pointers, count and storage)
//   push/wdata : write request; accepted when not full, or when full and a
//                pop happens on the same edge
//   pop        : read request; ignored when empty
//   head       : oldest entry
//   head_next  : entry behind the oldest (valid when count >= 2)
//   count      : number of stored entries
//   full/empty : count == DEPTH / count == 0
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module hring_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      count_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == CNT_FULL);
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign head_next = mem_r[rd_ptr_r + PTR_ONE];

    // Effective read/write strobes; a full FIFO still accepts a write when it pops that edge.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; cleared on reset so stale data never reaches the head outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/hring_node_port_ctrl.sv
// ---------------------------------------------------------------------------
// hring_node_port_ctrl
// Local-port controller for one local router port pair of a hierarchical-ring
// node. Buffers core flits for injection into the bufferless router and
// buffers ejected flits towards the core.
//   clk, rst     : clock, synchronous active-high reset
//   port_if      : slave side of the core/router handshake bundle
//   starve       : injection head has waited STARVE_LIMIT un-acked cycles
//   ej_overflow  : sticky, an ejected flit was dropped (ejection FIFO full)
//   inj_count    : flits accepted by the router, wraps modulo 2^CNT_W
// Injection path: core push -> FIFO -> registered portl_ci (one edge later).
// The FIFO entry stays stored until the router acks it, so portl_ci is always
// a copy of the FIFO head and INJ_DEPTH is the total injection capacity.
// ---------------------------------------------------------------------------
module hring_node_port_ctrl
    import hring_node_port_ctrl_pkg::*;
#(
    parameter int INJ_DEPTH    = 4,
    parameter int EJ_DEPTH     = 4,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    hring_node_port_ctrl_if.slave port_if,
    output logic                 starve,
    output logic                 ej_overflow,
    output logic [CNT_W-1:0]     inj_count
);

    localparam int IAW = $clog2(INJ_DEPTH);
    localparam int EAW = $clog2(EJ_DEPTH);
    localparam int SW  = $clog2(STARVE_LIMIT + 1);

    localparam logic [IAW:0]     INJ_CNT_TWO = {{(IAW-1){1'b0}}, 2'b10};
    localparam logic [SW-1:0]    STARVE_MAX  = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0]    STARVE_ONE  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] INJ_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    // Injection FIFO signals
    logic           inj_push_s;
    logic           inj_pop_s;
    flit_t          inj_head_s;
    flit_t          inj_head_next_s;
    logic [IAW:0]   inj_cnt_s;
    logic           inj_full_s;
    logic           inj_empty_s;

    // Ejection FIFO signals
    logic           ej_push_s;
    logic           ej_pop_s;
    flit_t          ej_head_s;
    flit_t          ej_head_next_s;
    logic [EAW:0]   ej_cnt_s;
    logic           ej_full_s;
    logic           ej_empty_s;
    logic           ej_drop_s;
    logic           ej_unused_s;

    // Output-side state
    flit_t          portl_ci_r;
    flit_t          portl_ci_nxt_s;
    logic [SW-1:0]  starve_cnt_r;
    logic [SW-1:0]  starve_cnt_nxt_s;
    logic           starve_r;
    logic           ej_overflow_r;
    logic [CNT_W-1:0] inj_count_r;

    // ------------------------------------------------------------------
    // Injection direction
    // ------------------------------------------------------------------
    // core_in_ready reflects occupancy before any same-edge pop: no bypass.
    assign port_if.core_in_ready = ~inj_full_s;
    assign port_if.portl_ci      = portl_ci_r;

    // Push/pop strobes; an ack is only honoured while a flit is actually offered.
    always_comb begin
        inj_push_s = port_if.core_in_valid & ~inj_full_s;
        inj_pop_s  = flit_present(portl_ci_r) & port_if.portl_ack;
    end

    hring_sync_fifo #(
        .WIDTH (CONTROL_W),
        .DEPTH (INJ_DEPTH)
    ) u_inj_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inj_push_s),
        .wdata     (port_if.core_in_flit),
        .pop       (inj_pop_s),
        .head      (inj_head_s),
        .head_next (inj_head_next_s),
        .count     (inj_cnt_s),
        .full      (inj_full_s),
        .empty     (inj_empty_s)
    );

    // Next offered flit: the head left after this edge's pop, drawn only from
    // entries already stored, so a flit pushed this edge shows one edge later.
    always_comb begin
        portl_ci_nxt_s = '0;
        if (inj_pop_s) begin
            if (inj_cnt_s >= INJ_CNT_TWO) begin
                portl_ci_nxt_s = mark_valid(inj_head_next_s);
            end else begin
                portl_ci_nxt_s = '0;
            end
        end else begin
            if (!inj_empty_s) begin
                portl_ci_nxt_s = mark_valid(inj_head_s);
            end else begin
                portl_ci_nxt_s = '0;
            end
        end
    end

    // Starvation counter: counts consecutive offered-but-refused edges, saturating.
    always_comb begin
        starve_cnt_nxt_s = '0;
        if (flit_present(portl_ci_r) && !port_if.portl_ack) begin
            if (starve_cnt_r == STARVE_MAX) begin
                starve_cnt_nxt_s = starve_cnt_r;
            end else begin
                starve_cnt_nxt_s = starve_cnt_r + STARVE_ONE;
            end
        end else begin
            starve_cnt_nxt_s = '0;
        end
    end

    // Registered injection outputs: offered flit, starvation state, accepted-flit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            portl_ci_r   <= '0;
            starve_cnt_r <= '0;
            starve_r     <= 1'b0;
            inj_count_r  <= '0;
        end else begin
            portl_ci_r   <= portl_ci_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
            starve_r     <= (starve_cnt_nxt_s == STARVE_MAX);
            if (inj_pop_s) begin
                inj_count_r <= inj_count_r + INJ_ONE;
            end else begin
                inj_count_r <= inj_count_r;
            end
        end
    end

    assign starve    = starve_r;
    assign inj_count = inj_count_r;

    // ------------------------------------------------------------------
    // Ejection direction
    // ------------------------------------------------------------------
    // The router cannot be stalled: every present flit is written, or dropped if no room.
    always_comb begin
        ej_push_s = flit_present(port_if.portl_co);
        ej_pop_s  = ~ej_empty_s & port_if.core_out_ready;
        ej_drop_s = ej_push_s & ej_full_s & ~ej_pop_s;
    end

    hring_sync_fifo #(
        .WIDTH (CONTROL_W),
        .DEPTH (EJ_DEPTH)
    ) u_ej_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ej_push_s),
        .wdata     (port_if.portl_co),
        .pop       (ej_pop_s),
        .head      (ej_head_s),
        .head_next (ej_head_next_s),
        .count     (ej_cnt_s),
        .full      (ej_full_s),
        .empty     (ej_empty_s)
    );

    // The ejection side never looks past the head nor at the raw occupancy.
    assign ej_unused_s = ^{ej_head_next_s, ej_cnt_s};

    assign port_if.core_out_flit  = ej_head_s;
    assign port_if.core_out_valid = ~ej_empty_s;

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ej_overflow_r <= 1'b0;
        end else if (ej_drop_s) begin
            ej_overflow_r <= 1'b1;
        end else begin
            ej_overflow_r <= ej_overflow_r;
        end
    end

    assign ej_overflow = ej_overflow_r;

endmodule

// File: tb/tb_hring_node_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hring_node_port_ctrl
// Self-checking bench for hring_node_port_ctrl: directed scenarios followed
// by randomized traffic, checked every cycle against a queue-based model.
// ---------------------------------------------------------------------------
module tb_hring_node_port_ctrl;
    import hring_node_port_ctrl_pkg::*;

    localparam int INJ_D = 4;
    localparam int EJ_D  = 4;
    localparam int SL    = 16;
    localparam int CW    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hring_node_port_ctrl_if bus();
    logic          starve;
    logic          ej_overflow;
    logic [CW-1:0] inj_count;

    hring_node_port_ctrl #(
        .INJ_DEPTH    (INJ_D),
        .EJ_DEPTH     (EJ_D),
        .STARVE_LIMIT (SL),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .port_if     (bus),
        .starve      (starve),
        .ej_overflow (ej_overflow),
        .inj_count   (inj_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: what the block holds after the most recent edge.
    typedef struct {
        flit_t f;
        int    at;      // edge at which the core handed the flit over
    } inj_ent_t;

    inj_ent_t inj_q[$];
    flit_t    ej_q[$];
    int       edge_n       = 0;
    int       m_inj_cnt    = 0;
    int       m_starve_run = 0;
    bit       m_ovf        = 1'b0;

    function automatic flit_t set_vbit(input flit_t f);
        return f | (flit_t'(1) << CTRL_VALID);
    endfunction

    function automatic void check(input string name, input flit_t act_v, input flit_t exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act_v, exp_v);
        end
    endfunction

    // Scoreboard/monitor: compare outputs with the model, then advance the model
    // using the inputs the coming edge will sample.
    always @(negedge clk) begin
        bit    vis;
        bit    pop_i;
        bit    push_i;
        bit    pop_e;
        flit_t exp_ci;
        inj_ent_t ent;

        // A queued flit is offered once an edge has passed since the core handed it over.
        vis    = (inj_q.size() > 0) && (inj_q[0].at < edge_n);
        exp_ci = vis ? set_vbit(inj_q[0].f) : '0;

        check("portl_ci",       bus.portl_ci, exp_ci);
        check("core_in_ready",  flit_t'(bus.core_in_ready), flit_t'(inj_q.size() < INJ_D));
        check("core_out_valid", flit_t'(bus.core_out_valid), flit_t'(ej_q.size() > 0));
        if (ej_q.size() > 0) begin
            check("core_out_flit", bus.core_out_flit, ej_q[0]);
        end
        check("starve",      flit_t'(starve), flit_t'(m_starve_run >= SL));
        check("ej_overflow", flit_t'(ej_overflow), flit_t'(m_ovf));
        check("inj_count",   flit_t'(inj_count), flit_t'(CW'(m_inj_cnt)));

        edge_n++;
        if (rst) begin
            inj_q.delete();
            ej_q.delete();
            m_inj_cnt    = 0;
            m_starve_run = 0;
            m_ovf        = 1'b0;
        end else begin
            pop_i  = vis && bus.portl_ack;
            push_i = bus.core_in_valid && (inj_q.size() < INJ_D);
            if (vis && !bus.portl_ack) begin
                if (m_starve_run < SL) m_starve_run++;
            end else begin
                m_starve_run = 0;
            end
            if (pop_i) begin
                void'(inj_q.pop_front());
                m_inj_cnt++;
            end
            if (push_i) begin
                ent.f  = bus.core_in_flit;
                ent.at = edge_n;
                inj_q.push_back(ent);
            end
            pop_e = (ej_q.size() > 0) && bus.core_out_ready;
            if (pop_e) void'(ej_q.pop_front());
            if (bus.portl_co[CTRL_VALID]) begin
                if (ej_q.size() < EJ_D) ej_q.push_back(bus.portl_co);
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one flit until the core-side handshake completes, bounded by max_cyc.
    task automatic push_flit(input flit_t f, input int max_cyc);
        bit done;
        done = 1'b0;
        bus.core_in_flit  = f;
        bus.core_in_valid = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.core_in_ready) begin
                done = 1'b1;
                step();
                break;
            end
            step();
        end
        bus.core_in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: core_in_ready stayed 0 for %0d cycles, required 1", max_cyc);
        end
    endtask

    function automatic flit_t rnd_flit(input bit v);
        flit_t f;
        f = '0;
        for (int i = 0; i < 4; i++) f[i*32 +: 32] = $urandom;
        f[143:128]    = 16'($urandom);
        f[CTRL_VALID] = v;
        return f;
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        flit_t fl [5];
        rst                = 1'b1;
        bus.core_in_flit   = '0;
        bus.core_in_valid  = 1'b0;
        bus.portl_ack      = 1'b0;
        bus.portl_co       = '0;
        bus.core_out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Immediate ack
        bus.portl_ack = 1'b1;
        push_flit(144'h0aaaaaaaaaabcdef0123456789abcdef1857, 4);
        repeat (4) step();

        // Withheld ack: three flits wait, then drain back-to-back
        bus.portl_ack = 1'b0;
        for (int k = 0; k < 3; k++) push_flit(rnd_flit(1'b0), 4);
        repeat (20) step();
        bus.portl_ack = 1'b1;
        repeat (6) step();

        // Injection full: fifth flit is held by the core until space frees up
        bus.portl_ack = 1'b0;
        for (int k = 0; k < 5; k++) fl[k] = rnd_flit(k[0]);
        for (int k = 0; k < 4; k++) push_flit(fl[k], 4);
        bus.core_in_flit  = fl[4];
        bus.core_in_valid = 1'b1;
        repeat (3) step();
        bus.portl_ack = 1'b1;
        push_flit(fl[4], 20);
        repeat (8) step();

        // Ejection overflow with the core stalled
        bus.core_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.portl_co = rnd_flit(1'b1);
            step();
        end
        bus.portl_co = '0;
        step();
        bus.core_out_ready = 1'b1;
        repeat (6) step();
        do_reset(1);

        // Ejection at full with a same-edge pop: no overflow
        bus.core_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.core_out_ready = (k == 4);
            bus.portl_co       = rnd_flit(1'b1);
            step();
        end
        bus.portl_co       = '0;
        bus.core_out_ready = 1'b0;
        step();
        bus.core_out_ready = 1'b1;
        repeat (6) step();

        // Mid-operation reset with two flits in each direction
        bus.portl_ack      = 1'b0;
        bus.core_out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.portl_co = rnd_flit(1'b1);
            push_flit(rnd_flit(1'b1), 4);
        end
        bus.portl_co = '0;
        step();
        do_reset(1);
        repeat (3) step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bus.core_in_valid  = ($urandom_range(0, 3) != 0);
            bus.core_in_flit   = rnd_flit(1'($urandom));
            bus.portl_ack      = ($urandom_range(0, 2) != 0);
            bus.portl_co       = rnd_flit($urandom_range(0, 2) == 0);
            bus.core_out_ready = ($urandom_range(0, 3) != 0);
            rst                = ($urandom_range(0, 499) == 0);
            step();
        end
        rst                = 1'b0;
        bus.core_in_valid  = 1'b0;
        bus.portl_ack      = 1'b1;
        bus.portl_co       = '0;
        bus.core_out_ready = 1'b1;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
